// File: rtl/alu_mem_stage.sv
// Execute/memory stage: ALU control decode, 16-bit ALU with flags, and a
// word-organised data memory addressed by the ALU result.
module alu_mem_stage #(
  parameter int MEM_WORDS = 64
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [1:0]  ALUOp,
  input  logic [3:0]  Funct,
  input  logic [2:0]  Opcode,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [15:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [3:0]  ALUCtrl,
  output logic [15:0] Result,
  output logic        Zero,
  output logic        Overflow,
  output logic        CarryOut,
  output logic [15:0] ReadData
);

  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_NOR = 3'b011,
    OP_ADD = 3'b100,
    OP_SLT = 3'b101,
    OP_SLL = 3'b110,
    OP_SRL = 3'b111
  } alu_op_e;

  alu_op_e     alu_op;
  logic        bnegate;
  logic [15:0] b_eff;
  logic [16:0] sum;
  logic        is_arith;
  logic        ovf_raw;
  logic [15:0] alu_result;

  logic [AW-1:0] mem_idx;
  logic [15:0]   mem_q [MEM_WORDS];
  logic [15:0]   mem_d [MEM_WORDS];

  // ALU control decode
  always_comb begin
    alu_op  = OP_ADD;
    bnegate = 1'b0;
    unique case (ALUOp)
      2'b00: begin
        alu_op  = OP_ADD;
        bnegate = 1'b0;
      end
      2'b01: begin
        alu_op  = OP_ADD;
        bnegate = 1'b1;
      end
      2'b10: begin
        case (Funct)
          4'b0000: alu_op = OP_ADD;
          4'b0001: begin
            alu_op  = OP_ADD;
            bnegate = 1'b1;
          end
          4'b0010: alu_op = OP_AND;
          4'b0011: alu_op = OP_OR;
          4'b0100: alu_op = OP_XOR;
          4'b0101: alu_op = OP_NOR;
          4'b0110: begin
            alu_op  = OP_SLT;
            bnegate = 1'b1;
          end
          4'b0111: alu_op = OP_SLL;
          4'b1000: alu_op = OP_SRL;
          default: alu_op = OP_ADD;
        endcase
      end
      2'b11: begin
        case (Opcode)
          3'b001:  alu_op = OP_ADD;
          3'b010:  alu_op = OP_AND;
          3'b011:  alu_op = OP_OR;
          3'b100: begin
            alu_op  = OP_SLT;
            bnegate = 1'b1;
          end
          default: alu_op = OP_ADD;
        endcase
      end
      default: begin
        alu_op  = OP_ADD;
        bnegate = 1'b0;
      end
    endcase
  end

  assign ALUCtrl = {bnegate, alu_op};

  // Shared adder feeds ADD/SUB and the signed compare for SLT
  always_comb begin
    b_eff    = bnegate ? ~B : B;
    sum      = {1'b0, A} + {1'b0, b_eff} + {16'b0, bnegate};
    is_arith = (alu_op == OP_ADD) || (alu_op == OP_SLT);
    ovf_raw  = (A[15] == b_eff[15]) && (sum[15] != A[15]);

    alu_result = 16'h0000;
    case (alu_op)
      OP_AND:  alu_result = A & B;
      OP_OR:   alu_result = A | B;
      OP_XOR:  alu_result = A ^ B;
      OP_NOR:  alu_result = ~(A | B);
      OP_ADD:  alu_result = sum[15:0];
      OP_SLT:  alu_result = {15'b0, sum[15] ^ ovf_raw};
      OP_SLL:  alu_result = A << B[3:0];
      OP_SRL:  alu_result = A >> B[3:0];
      default: alu_result = 16'h0000;
    endcase
  end

  assign Result   = alu_result;
  assign Zero     = (alu_result == 16'h0000);
  assign Overflow = is_arith & ovf_raw;
  assign CarryOut = is_arith & sum[16];

  // Byte address: bit 0 and bits above the word index are ignored
  assign mem_idx = Result[AW:1];

  always_comb begin
    mem_d = mem_q;
    if (MemWrite) begin
      mem_d[mem_idx] = WriteData;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign ReadData = MemRead ? mem_q[mem_idx] : 16'h0000;

endmodule

// File: tb/tb_alu_mem_stage.sv
// Self-checking bench for alu_mem_stage: directed cases plus randomized
// traffic against an arithmetic reference model and a memory array.
module tb_alu_mem_stage;

  localparam int MEM_WORDS = 64;

  logic        Clock;
  logic        Reset;
  logic [1:0]  ALUOp;
  logic [3:0]  Funct;
  logic [2:0]  Opcode;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [3:0]  ALUCtrl;
  logic [15:0] Result;
  logic        Zero;
  logic        Overflow;
  logic        CarryOut;
  logic [15:0] ReadData;

  int checks;
  int failures;

  logic [15:0] memModel [MEM_WORDS];

  typedef enum {M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLL, M_SRL} model_op_e;

  alu_mem_stage #(.MEM_WORDS(MEM_WORDS)) dut (
    .Clock(Clock), .Reset(Reset), .ALUOp(ALUOp), .Funct(Funct), .Opcode(Opcode),
    .A(A), .B(B), .WriteData(WriteData), .MemRead(MemRead), .MemWrite(MemWrite),
    .ALUCtrl(ALUCtrl), .Result(Result), .Zero(Zero), .Overflow(Overflow),
    .CarryOut(CarryOut), .ReadData(ReadData)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic model_op_e pickOp(input logic [1:0] aluOp, input logic [3:0] fn,
                                       input logic [2:0] opc);
    model_op_e op;
    op = M_ADD;
    case (aluOp)
      2'd0: op = M_ADD;
      2'd1: op = M_SUB;
      2'd2: case (fn)
              4'd0: op = M_ADD;  4'd1: op = M_SUB;  4'd2: op = M_AND;
              4'd3: op = M_OR;   4'd4: op = M_XOR;  4'd5: op = M_NOR;
              4'd6: op = M_SLT;  4'd7: op = M_SLL;  4'd8: op = M_SRL;
              default: op = M_ADD;
            endcase
      default: case (opc)
              3'd1: op = M_ADD;  3'd2: op = M_AND;  3'd3: op = M_OR;
              3'd4: op = M_SLT;
              default: op = M_ADD;
            endcase
    endcase
    return op;
  endfunction

  function automatic logic [3:0] ctrlFor(input model_op_e op);
    case (op)
      M_ADD: return 4'b0100;  M_SUB: return 4'b1100;  M_AND: return 4'b0000;
      M_OR:  return 4'b0001;  M_XOR: return 4'b0010;  M_NOR: return 4'b0011;
      M_SLT: return 4'b1101;  M_SLL: return 4'b0110;  default: return 4'b0111;
    endcase
  endfunction

  // Reference ALU built from integer arithmetic rather than gate equations
  task automatic modelAlu(input model_op_e op, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] res, output logic ov, output logic co);
    int ua, ub, sa, sb, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    res = 16'h0; ov = 1'b0; co = 1'b0;
    case (op)
      M_ADD: begin
        res = 16'(ua + ub);
        co  = (ua + ub) > 65535;
        sr  = sa + sb;
        ov  = (sr > 32767) || (sr < -32768);
      end
      M_SUB, M_SLT: begin
        res = 16'(ua - ub);
        co  = ua >= ub;
        sr  = sa - sb;
        ov  = (sr > 32767) || (sr < -32768);
        if (op == M_SLT) res = (sa < sb) ? 16'd1 : 16'd0;
      end
      M_AND: res = a & b;
      M_OR:  res = a | b;
      M_XOR: res = a ^ b;
      M_NOR: res = ~(a | b);
      M_SLL: res = 16'(ua * (1 << int'(b[3:0])));
      M_SRL: res = 16'(ua / (1 << int'(b[3:0])));
      default: res = 16'h0;
    endcase
  endtask

  function automatic int wordIndex(input logic [15:0] addr);
    return (int'(addr) / 2) % MEM_WORDS;
  endfunction

  task automatic applyStimulus(input logic rst, input logic [1:0] aluOp, input logic [3:0] fn,
                               input logic [2:0] opc, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] wd, input logic rd, input logic wr);
    Reset = rst; ALUOp = aluOp; Funct = fn; Opcode = opc;
    A = a; B = b; WriteData = wd; MemRead = rd; MemWrite = wr;
    #1;
  endtask

  task automatic checkModel(input string tag);
    model_op_e   op;
    logic [15:0] res;
    logic        ov, co;
    logic [15:0] rdExp;
    op = pickOp(ALUOp, Funct, Opcode);
    modelAlu(op, A, B, res, ov, co);
    rdExp = MemRead ? memModel[wordIndex(res)] : 16'h0;
    checkOutput({tag, ".ctrl"}, 32'(ALUCtrl), 32'(ctrlFor(op)));
    checkOutput({tag, ".res"},  32'(Result), 32'(res));
    checkOutput({tag, ".zero"}, 32'(Zero), 32'(res == 16'h0));
    checkOutput({tag, ".ovf"},  32'(Overflow), 32'(ov));
    checkOutput({tag, ".co"},   32'(CarryOut), 32'(co));
    checkOutput({tag, ".rd"},   32'(ReadData), 32'(rdExp));
  endtask

  // Commits the model memory at the rising edge, then returns to mid-low phase
  task automatic advanceClock();
    model_op_e   op;
    logic [15:0] res;
    logic        ov, co;
    op = pickOp(ALUOp, Funct, Opcode);
    modelAlu(op, A, B, res, ov, co);
    @(posedge Clock);
    if (Reset) begin
      for (int i = 0; i < MEM_WORDS; i++) memModel[i] = 16'h0;
    end else if (MemWrite) begin
      memModel[wordIndex(res)] = WriteData;
    end
    @(negedge Clock);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < MEM_WORDS; i++) memModel[i] = 16'h0;
    applyStimulus(1'b1, 2'b00, 4'h0, 3'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    @(negedge Clock);

    applyStimulus(1'b1, 2'b00, 4'h0, 3'h0, 16'h0010, 16'h0, 16'h0, 1'b0, 1'b0);
    checkOutput("reset.rd_off", 32'(ReadData), 32'h0);
    advanceClock();
    applyStimulus(1'b0, 2'b00, 4'h0, 3'h0, 16'h0010, 16'h0, 16'h0, 1'b1, 1'b0);
    checkOutput("reset.rd_cleared", 32'(ReadData), 32'h0);
    advanceClock();

    applyStimulus(1'b0, 2'b10, 4'b0000, 3'h0, 16'h7FFF, 16'h0001, 16'h0, 1'b0, 1'b0);
    checkOutput("add.ctrl", 32'(ALUCtrl), 32'b0100);
    checkOutput("add.res", 32'(Result), 32'h8000);
    checkOutput("add.ovf", 32'(Overflow), 32'h1);
    checkOutput("add.co", 32'(CarryOut), 32'h0);
    checkOutput("add.zero", 32'(Zero), 32'h0);
    advanceClock();

    applyStimulus(1'b0, 2'b01, 4'h0, 3'h0, 16'h1234, 16'h1234, 16'h0, 1'b0, 1'b0);
    checkOutput("beq.ctrl", 32'(ALUCtrl), 32'b1100);
    checkOutput("beq.res", 32'(Result), 32'h0);
    checkOutput("beq.zero", 32'(Zero), 32'h1);
    checkOutput("beq.co", 32'(CarryOut), 32'h1);
    checkOutput("beq.ovf", 32'(Overflow), 32'h0);
    advanceClock();

    applyStimulus(1'b0, 2'b10, 4'b0110, 3'h0, 16'hFFFF, 16'h0001, 16'h0, 1'b0, 1'b0);
    checkOutput("slt.neg", 32'(Result), 32'h1);
    applyStimulus(1'b0, 2'b10, 4'b0110, 3'h0, 16'h0001, 16'hFFFF, 16'h0, 1'b0, 1'b0);
    checkOutput("slt.pos", 32'(Result), 32'h0);
    applyStimulus(1'b0, 2'b10, 4'b0111, 3'h0, 16'h0001, 16'h000F, 16'h0, 1'b0, 1'b0);
    checkOutput("sll.15", 32'(Result), 32'h8000);
    applyStimulus(1'b0, 2'b10, 4'b1000, 3'h0, 16'h8000, 16'h0004, 16'h0, 1'b0, 1'b0);
    checkOutput("srl.4", 32'(Result), 32'h0800);
    applyStimulus(1'b0, 2'b11, 4'h0, 3'b010, 16'h00F0, 16'h0FF0, 16'h0, 1'b0, 1'b0);
    checkOutput("andi.ctrl", 32'(ALUCtrl), 32'b0000);
    applyStimulus(1'b0, 2'b11, 4'h0, 3'b100, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    checkOutput("slti.ctrl", 32'(ALUCtrl), 32'b1101);
    applyStimulus(1'b0, 2'b10, 4'b1111, 3'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    checkOutput("dflt.ctrl", 32'(ALUCtrl), 32'b0100);
    advanceClock();

    applyStimulus(1'b0, 2'b00, 4'h0, 3'h0, 16'h0008, 16'h0002, 16'hBEEF, 1'b0, 1'b1);
    advanceClock();
    applyStimulus(1'b0, 2'b00, 4'h0, 3'h0, 16'h000A, 16'h0000, 16'h0, 1'b1, 1'b0);
    checkOutput("ld.0A", 32'(ReadData), 32'hBEEF);
    applyStimulus(1'b0, 2'b00, 4'h0, 3'h0, 16'h000B, 16'h0000, 16'h0, 1'b1, 1'b0);
    checkOutput("ld.0B", 32'(ReadData), 32'hBEEF);
    applyStimulus(1'b0, 2'b00, 4'h0, 3'h0, 16'h008A, 16'h0000, 16'h0, 1'b1, 1'b0);
    checkOutput("ld.8A", 32'(ReadData), 32'hBEEF);
    applyStimulus(1'b0, 2'b00, 4'h0, 3'h0, 16'h000A, 16'h0000, 16'h0, 1'b0, 1'b0);
    checkOutput("ld.noread", 32'(ReadData), 32'h0);
    advanceClock();

    applyStimulus(1'b1, 2'b00, 4'h0, 3'h0, 16'h0004, 16'h0000, 16'h1111, 1'b0, 1'b1);
    advanceClock();
    applyStimulus(1'b0, 2'b00, 4'h0, 3'h0, 16'h0004, 16'h0000, 16'h0, 1'b1, 1'b0);
    checkOutput("rst.nowrite", 32'(ReadData), 32'h0);
    applyStimulus(1'b0, 2'b00, 4'h0, 3'h0, 16'h000A, 16'h0000, 16'h0, 1'b1, 1'b0);
    checkOutput("rst.cleared", 32'(ReadData), 32'h0);
    applyStimulus(1'b0, 2'b00, 4'h0, 3'h0, 16'h0004, 16'h0000, 16'h2222, 1'b1, 1'b1);
    checkOutput("rst.rdw_old", 32'(ReadData), 32'h0);
    advanceClock();
    applyStimulus(1'b0, 2'b00, 4'h0, 3'h0, 16'h0004, 16'h0000, 16'h0, 1'b1, 1'b0);
    checkOutput("rst.postwrite", 32'(ReadData), 32'h2222);
    advanceClock();

    for (int n = 0; n < 400; n++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        ra = 16'($urandom_range(0, 255));
        rb = 16'($urandom_range(0, 15));
      end
      applyStimulus($urandom_range(0, 49) == 0, 2'($urandom), 4'($urandom), 3'($urandom),
                    ra, rb, 16'($urandom), 1'($urandom), $urandom_range(0, 2) == 0);
      checkModel($sformatf("rnd%0d", n));
      advanceClock();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
